// File: rtl/groestl_avalon_master.sv
// Avalon-MM master that feeds a host word stream into the Groestl slave register map,
// polls for completion, clears hash_ready and returns the digest as one wide word.
module groestl_avalon_master #(
    parameter int POLL_GAP     = 16,
    parameter int TIMEOUT      = 4096,
    parameter int DIGEST_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 msg_data,
    input  logic                        msg_first,
    input  logic                        msg_last,
    input  logic                        msg_valid,
    output logic                        msg_ready,
    output logic [32*DIGEST_WORDS-1:0]  digest,
    output logic                        digest_valid,
    output logic                        busy,
    output logic                        timeout_err,
    output logic [4:0]                  avm_address,
    output logic [31:0]                 avm_writedata,
    output logic [3:0]                  avm_byteenable,
    output logic                        avm_write,
    output logic                        avm_read,
    output logic                        avm_chipselect,
    input  logic [31:0]                 avm_readdata
);

    localparam int PCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int ICW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_CTRL, WR_DATA, WAIT_WORD, POLL_GAP_S, POLL_RD, POLL_CHK,
        CLR, RD_DIG, RD_CAP, DONE
    } state_t;

    state_t           state_reg, state_next;
    logic             phase_reg, phase_next;
    logic [31:0]      word_reg, word_next;
    logic             first_reg, first_next;
    logic             last_reg, last_next;
    logic [GCW-1:0]   gap_reg, gap_next;
    logic [PCW-1:0]   poll_reg, poll_next, poll_inc;
    logic [ICW-1:0]   idx_reg, idx_next;
    logic             terr_reg, terr_next;
    logic             ready_int;
    logic             cap_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            phase_reg <= 1'b0;
            word_reg  <= '0;
            first_reg <= 1'b0;
            last_reg  <= 1'b0;
            gap_reg   <= '0;
            poll_reg  <= '0;
            idx_reg   <= '0;
            terr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            word_reg  <= word_next;
            first_reg <= first_next;
            last_reg  <= last_next;
            gap_reg   <= gap_next;
            poll_reg  <= poll_next;
            idx_reg   <= idx_next;
            terr_reg  <= terr_next;
        end
    end

    assign poll_inc = (poll_reg == '1) ? poll_reg : poll_reg + 1'b1;

    // Single-strobe states that are followed by another strobe use phase_reg
    // to insert the mandatory idle cycle between bus accesses.
    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        word_next     = word_reg;
        first_next    = first_reg;
        last_next     = last_reg;
        gap_next      = gap_reg;
        poll_next     = poll_reg;
        idx_next      = idx_reg;
        terr_next     = terr_reg;
        ready_int     = 1'b0;
        cap_en        = 1'b0;
        digest_valid  = 1'b0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_address   = 5'h00;
        avm_writedata = 32'h0;
        case (state_reg)
            IDLE: begin
                ready_int = 1'b1;
                if (msg_valid && msg_first) begin
                    word_next  = msg_data;
                    first_next = 1'b1;
                    last_next  = msg_last;
                    poll_next  = '0;
                    terr_next  = 1'b0;
                    phase_next = 1'b0;
                    state_next = WR_CTRL;
                end
            end
            WR_CTRL: begin
                if (!phase_reg) begin
                    avm_write     = 1'b1;
                    avm_address   = 5'h00;
                    avm_writedata = first_reg ? 32'h8 : 32'h0;
                    phase_next    = 1'b1;
                end else begin
                    phase_next = 1'b0;
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                avm_write     = 1'b1;
                avm_address   = 5'h01;
                avm_writedata = word_reg;
                gap_next      = '0;
                state_next    = last_reg ? POLL_GAP_S : WAIT_WORD;
            end
            WAIT_WORD: begin
                ready_int = 1'b1;
                if (msg_valid) begin
                    word_next  = msg_data;
                    first_next = 1'b0;
                    last_next  = msg_last;
                    phase_next = 1'b0;
                    state_next = WR_CTRL;
                end
            end
            POLL_GAP_S: begin
                if (gap_reg == GCW'(POLL_GAP - 1)) begin
                    gap_next   = '0;
                    state_next = POLL_RD;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            POLL_RD: begin
                avm_read    = 1'b1;
                avm_address = 5'h00;
                state_next  = POLL_CHK;
            end
            POLL_CHK: begin
                if (avm_readdata[0]) begin
                    phase_next = 1'b0;
                    state_next = CLR;
                end else begin
                    poll_next = poll_inc;
                    if ((TIMEOUT != 0) && (poll_inc == PCW'(TIMEOUT))) begin
                        terr_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = POLL_GAP_S;
                    end
                end
            end
            CLR: begin
                if (!phase_reg) begin
                    avm_write     = 1'b1;
                    avm_address   = 5'h04;
                    avm_writedata = 32'h0;
                    phase_next    = 1'b1;
                end else begin
                    phase_next = 1'b0;
                    idx_next   = '0;
                    state_next = RD_DIG;
                end
            end
            RD_DIG: begin
                avm_read    = 1'b1;
                avm_address = 5'h10 + 5'(idx_reg);
                state_next  = RD_CAP;
            end
            RD_CAP: begin
                cap_en = 1'b1;
                if (idx_reg == ICW'(DIGEST_WORDS - 1)) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = RD_DIG;
                end
            end
            DONE: begin
                digest_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word i read from 0x10+i lands in the i-th 32-bit slice counted from the MSB end.
    genvar gi;
    generate
        for (gi = 0; gi < DIGEST_WORDS; gi++) begin : g_dig
            logic [31:0] dword_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dword_reg <= '0;
                end else if (cap_en && (idx_reg == ICW'(gi))) begin
                    dword_reg <= avm_readdata;
                end
            end
            assign digest[32*(DIGEST_WORDS-1-gi) +: 32] = dword_reg;
        end
    endgenerate

    // Gated so msg_ready reads 0 while reset is held even though the FSM sits in IDLE.
    assign msg_ready      = ready_int & reset;
    assign busy           = (state_reg != IDLE);
    assign timeout_err    = terr_reg;
    assign avm_byteenable = 4'hF;
    assign avm_chipselect = avm_write | avm_read;

endmodule

// File: tb/tb_groestl_avalon_master.sv
// Bench for groestl_avalon_master: behavioural Groestl slave, bus scoreboard and
// protocol monitor, with one task per scenario.
module tb_groestl_avalon_master;

    localparam int PG = 2;
    localparam int TO = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   msg_data;
    logic          msg_first, msg_last, msg_valid;
    logic          msg_ready;
    logic [255:0]  digest;
    logic          digest_valid, busy, timeout_err;
    logic [4:0]    avm_address;
    logic [31:0]   avm_writedata;
    logic [3:0]    avm_byteenable;
    logic          avm_write, avm_read, avm_chipselect;
    logic [31:0]   avm_readdata = 32'h0;

    groestl_avalon_master #(.POLL_GAP(PG), .TIMEOUT(TO), .DIGEST_WORDS(DW)) dut (
        .clk(clk), .reset(reset),
        .msg_data(msg_data), .msg_first(msg_first), .msg_last(msg_last),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .digest(digest), .digest_valid(digest_valid), .busy(busy), .timeout_err(timeout_err),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_write(avm_write), .avm_read(avm_read),
        .avm_chipselect(avm_chipselect), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [38:0]   exp_q[$];
    logic [38:0]   obs_q[$];
    int            viol = 0;
    bit            prev_strobe = 1'b0;
    int            dv_count = 0;
    logic [255:0]  last_digest = '0;
    int            ready_after = 0;
    int            poll_num = 0;
    logic [31:0]   dig_mem[8];

    // Slave: STATUS reports ready from the ready_after-th poll onwards (0 = never).
    always @(posedge clk) begin
        if (avm_read) begin
            if (avm_address == 5'h00) begin
                poll_num++;
                avm_readdata <= {31'b0, (ready_after != 0 && poll_num >= ready_after)};
            end else if (avm_address >= 5'h10) begin
                avm_readdata <= dig_mem[avm_address[2:0]];
            end else begin
                avm_readdata <= 32'hDEAD_BEEF;
            end
        end
    end

    always @(negedge clk) begin
        if (avm_write | avm_read) begin
            obs_q.push_back({avm_write, avm_read, avm_address, avm_write ? avm_writedata : 32'h0});
            if (avm_write) $display("bus W addr=%02h data=%08h", avm_address, avm_writedata);
            else           $display("bus R addr=%02h", avm_address);
            if (prev_strobe) viol++;
        end
        if (avm_chipselect !== (avm_write | avm_read)) viol++;
        if (avm_write && avm_read) viol++;
        if (avm_byteenable !== 4'hF) viol++;
        prev_strobe = avm_write | avm_read;
        if (digest_valid === 1'b1) begin
            dv_count++;
            last_digest = digest;
        end
    end

    task automatic push_w(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, 1'b0, a, d});
    endtask

    task automatic push_r(input logic [4:0] a);
        exp_q.push_back({1'b0, 1'b1, a, 32'h0});
    endtask

    task automatic push_tail(input int polls);
        for (int i = 0; i < polls; i++) push_r(5'h00);
        push_w(5'h04, 32'h0);
        for (int i = 0; i < DW; i++) push_r(5'(16 + i));
    endtask

    task automatic fill_digest(output logic [255:0] d);
        for (int i = 0; i < DW; i++) begin
            dig_mem[i] = $urandom;
            d[255 - 32*i -: 32] = dig_mem[i];
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic f, input logic l, output bit ok);
        msg_data = d; msg_first = f; msg_last = l; msg_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk);
            if (msg_ready) ok = 1'b1;
        end
        #1 msg_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (msg_ready !== 1'b0) $display("FAIL rst_msg_ready: got %b want 0", msg_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (digest !== 256'h0) $display("FAIL rst_digest: got %h want 0", digest); else n_pass++;
        n_checks++; if ({digest_valid, timeout_err, avm_write, avm_read, avm_chipselect} !== 5'b0)
            $display("FAIL rst_ctl: got %b want 00000", {digest_valid, timeout_err, avm_write, avm_read, avm_chipselect}); else n_pass++;
        n_checks++; if (avm_byteenable !== 4'hF) $display("FAIL rst_be: got %h want f", avm_byteenable); else n_pass++;
        n_checks++; if ({avm_address, avm_writedata} !== 37'h0) $display("FAIL rst_bus: got %h want 0", {avm_address, avm_writedata}); else n_pass++;
    endtask

    task automatic test_two_word();
        logic [255:0] exp_dig;
        logic [38:0]  e, o;
        bit ok;
        int dv0 = dv_count, v0 = viol;
        fill_digest(exp_dig);
        ready_after = 3; poll_num = 0;
        push_w(5'h00, 32'h8); push_w(5'h01, 32'h8000_0000);
        push_w(5'h00, 32'h0); push_w(5'h01, 32'hCC00_0000);
        push_tail(3);
        send_word(32'h8000_0000, 1'b1, 1'b0, ok);
        n_checks++; if (!ok) $display("FAIL two_accept0: got 0 want 1"); else n_pass++;
        send_word(32'hCC00_0000, 1'b0, 1'b1, ok);
        n_checks++; if (!ok) $display("FAIL two_accept1: got 0 want 1"); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL two_idle: busy still set, want idle"); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL two_bus_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL two_bus: got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        n_checks++; if (dv_count - dv0 != 1) $display("FAIL two_dv_pulses: got %0d want 1", dv_count - dv0); else n_pass++;
        n_checks++; if (last_digest !== exp_dig) $display("FAIL two_digest: got %h want %h", last_digest, exp_dig); else n_pass++;
        n_checks++; if (digest !== exp_dig) $display("FAIL two_digest_hold: got %h want %h", digest, exp_dig); else n_pass++;
        n_checks++; if (viol != v0) $display("FAIL two_protocol: got %0d violations want 0", viol - v0); else n_pass++;
    endtask

    task automatic test_timeout();
        logic [255:0] exp_dig;
        logic [38:0]  e, o;
        bit ok;
        int dv0 = dv_count, v0 = viol;
        ready_after = 0; poll_num = 0;
        push_w(5'h00, 32'h8); push_w(5'h01, 32'h1234_5678);
        for (int i = 0; i < TO; i++) push_r(5'h00);
        send_word(32'h1234_5678, 1'b1, 1'b1, ok);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL to_idle: busy still set, want idle"); else n_pass++;
        repeat (PG + 4) @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL to_bus_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL to_bus: got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL to_err_set: got %b want 1", timeout_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (dv_count != dv0) $display("FAIL to_no_digest: got %0d pulses want 0", dv_count - dv0); else n_pass++;
        fill_digest(exp_dig);
        ready_after = 1; poll_num = 0;
        push_w(5'h00, 32'h8); push_w(5'h01, 32'hA5A5_0001);
        push_tail(1);
        send_word(32'hA5A5_0001, 1'b1, 1'b1, ok);
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL to_err_clear: got %b want 0", timeout_err); else n_pass++;
        wait_idle(ok);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL to2_bus_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL to2_bus: got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        n_checks++; if (last_digest !== exp_dig) $display("FAIL to2_digest: got %h want %h", last_digest, exp_dig); else n_pass++;
        n_checks++; if (viol != v0) $display("FAIL to_protocol: got %0d violations want 0", viol - v0); else n_pass++;
    endtask

    task automatic test_drop_and_hold();
        logic [255:0] exp_dig;
        logic [38:0]  e, o;
        bit ok, seen;
        int rdy_hi = 0;
        send_word(32'h5555_AAAA, 1'b0, 1'b1, ok);
        n_checks++; if (!ok) $display("FAIL drop_ack: got 0 want 1"); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) $display("FAIL drop_bus: got %0d accesses want 0", obs_q.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else n_pass++;
        fill_digest(exp_dig);
        ready_after = 2; poll_num = 0;
        push_w(5'h00, 32'h8); push_w(5'h01, 32'h0F0F_0F0F);
        push_tail(2);
        send_word(32'h0F0F_0F0F, 1'b1, 1'b1, ok);
        msg_data = 32'hFFFF_0000; msg_first = 1'b0; msg_last = 1'b0; msg_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (msg_ready) rdy_hi++;
            if (digest_valid) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL hold_done: digest_valid never seen, want pulse"); else n_pass++;
        n_checks++; if (rdy_hi != 0) $display("FAIL hold_ready_low: got %0d ready cycles want 0", rdy_hi); else n_pass++;
        @(negedge clk);
        n_checks++; if (msg_ready !== 1'b1) $display("FAIL hold_ready_idle: got %b want 1", msg_ready); else n_pass++;
        @(posedge clk); #1 msg_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL hold_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL hold_bus_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL hold_bus: got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        n_checks++; if (last_digest !== exp_dig) $display("FAIL hold_digest: got %h want %h", last_digest, exp_dig); else n_pass++;
    endtask

    task automatic test_reset_mid_digest();
        logic [255:0] exp_dig;
        logic [38:0]  e, o;
        bit ok, hit;
        fill_digest(exp_dig);
        ready_after = 1; poll_num = 0;
        push_w(5'h00, 32'h8); push_w(5'h01, 32'h7777_0000);
        push_r(5'h00); push_w(5'h04, 32'h0);
        push_r(5'h10); push_r(5'h11); push_r(5'h12);
        send_word(32'h7777_0000, 1'b1, 1'b1, ok);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (avm_read && avm_address == 5'h12) hit = 1'b1;
        end
        n_checks++; if (!hit) $display("FAIL rstmid_reach: read of 0x12 never seen, want seen"); else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_checks++; if ({avm_write, avm_read, avm_chipselect} !== 3'b0) $display("FAIL rstmid_strobes: got %b want 000", {avm_write, avm_read, avm_chipselect}); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (digest !== 256'h0) $display("FAIL rstmid_digest: got %h want 0", digest); else n_pass++;
        n_checks++; if (msg_ready !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", msg_ready); else n_pass++;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rstmid_bus_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL rstmid_bus: got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        fill_digest(exp_dig);
        ready_after = 2; poll_num = 0;
        push_w(5'h00, 32'h8); push_w(5'h01, 32'h0000_00C3);
        push_tail(2);
        send_word(32'h0000_00C3, 1'b1, 1'b1, ok);
        wait_idle(ok);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rstmid2_bus_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL rstmid2_bus: got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        n_checks++; if (digest !== exp_dig) $display("FAIL rstmid2_digest: got %h want %h", digest, exp_dig); else n_pass++;
    endtask

    task automatic test_single_word();
        logic [255:0] exp_dig;
        logic [38:0]  e, o;
        logic [31:0]  w;
        bit ok;
        int dv0 = dv_count, v0 = viol;
        fill_digest(exp_dig);
        w = $urandom;
        ready_after = 1; poll_num = 0;
        push_w(5'h00, 32'h8); push_w(5'h01, w);
        push_tail(1);
        send_word(w, 1'b1, 1'b1, ok);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL single_idle: busy still set, want idle"); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL single_bus_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL single_bus: got %h want %h", o, e); else n_pass++;
        end
        exp_q.delete(); obs_q.delete();
        n_checks++; if (dv_count - dv0 != 1) $display("FAIL single_dv_pulses: got %0d want 1", dv_count - dv0); else n_pass++;
        n_checks++; if (last_digest !== exp_dig) $display("FAIL single_digest: got %h want %h", last_digest, exp_dig); else n_pass++;
        n_checks++; if (viol != v0) $display("FAIL single_protocol: got %0d violations want 0", viol - v0); else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        msg_data = '0; msg_first = 1'b0; msg_last = 1'b0; msg_valid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        test_two_word();
        test_timeout();
        test_drop_and_hold();
        test_reset_mid_digest();
        test_single_word();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
